// File: rtl/addsub_serial_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor: FSM states,
// opcode values and the chunk-counter width helper.
package addsub_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Counter width for n chunks; never narrower than one bit so that a
  // single-chunk configuration still has a legal counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_serial_add_chunk.sv
// CHUNK-bit ripple slice built from full-adder cells. Also exposes the
// carry into the slice MSB so the top level can form signed overflow.
module addsub_serial_add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out,
  output logic             carry_msb_in
);

  logic [CHUNK:0] c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c            = '0;
    sum          = '0;
    c[0]         = carry_in;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry_out    = c[CHUNK];
    carry_msb_in = c[CHUNK-1];
  end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice is reused WIDTH/CHUNK
// times, LSB chunk first. Subtract is a + ~b + ~borrow_in, so the operand
// inversion and carry seed happen once at accept time.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt;

  int               base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] full_sum;

  // Select the operand chunk addressed by the counter.
  always_comb begin
    base    = int'(cnt) * CHUNK;
    a_chunk = a_reg[base +: CHUNK];
    b_chunk = b_reg[base +: CHUNK];
  end

  addsub_serial_add_chunk #(.CHUNK(CHUNK)) u_slice (
    .a            (a_chunk),
    .b            (b_chunk),
    .carry_in     (carry_reg),
    .sum          (slice_sum),
    .carry_out    (slice_cout),
    .carry_msb_in (slice_cmsb)
  );

  // Partial result with the current chunk merged in; on the last chunk this
  // is the complete sum, so zero is evaluated over all WIDTH bits.
  always_comb begin
    full_sum               = acc_reg;
    full_sum[base +: CHUNK] = slice_sum;
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{op == OP_SUB}};
            carry_reg <= carry_in ^ (op == OP_SUB);
            cnt       <= '0;
            in_ready  <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_reg   <= full_sum;
          carry_reg <= slice_cout;
          if (cnt == LAST_CNT) begin
            sum       <= full_sum;
            carry_out <= slice_cout;
            overflow  <= slice_cmsb ^ slice_cout;
            zero      <= (full_sum == '0);
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
